// File: rtl/i2c_target_responder.sv
// rtl/i2c_target_responder.sv - I2C target: START/STOP detect, 7-bit address match, write sink and stretched read source
`timescale 1ns/1ps
// Ports:
//   clk_i, rst_i              system clock, asynchronous active-high reset
//   scl_i, sda_i              raw (asynchronous) bus pin levels
//   scl_oe_o, sda_oe_o        1 = pull the pin low (open drain)
//   wr_data_o/wr_valid_o      byte written by the master, 1-cycle valid pulse
//   wr_ready_i                sink ready; sampled at the 8th data bit (0 gives NACK)
//   rd_req_o                  1-cycle request for the next read byte
//   rd_data_i/rd_valid_i      read byte supply, only looked at in RD_WAIT
//   start_o, stop_o, busy_o   bus condition pulses and bus-busy level
module i2c_target_responder #(
  parameter logic [6:0]  TARGET_ADDR = 7'h22,
  parameter int unsigned SDA_HOLD    = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_oe_o,
  output logic       sda_oe_o,
  output logic [7:0] wr_data_o,
  output logic       wr_valid_o,
  input  logic       wr_ready_i,
  output logic       rd_req_o,
  input  logic [7:0] rd_data_i,
  input  logic       rd_valid_i,
  output logic       start_o,
  output logic       stop_o,
  output logic       busy_o
);

  localparam int HW = $clog2(SDA_HOLD + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_BYTE, S_WR_ACK,
    S_WR_NACK, S_RD_WAIT, S_RD_BYTE, S_RD_ACK, S_IGNORE
  } state_t;

  // Input synchronisers; reset to the idle (high) level so leaving reset
  // never manufactures an edge.
  logic [1:0] scl_sync, sda_sync;
  logic       scl_prev, sda_prev;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
      scl_prev <= scl_sync[1];
      sda_prev <= sda_sync[1];
    end
  end

  logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
  assign scl_s     = scl_sync[1];
  assign sda_s     = sda_sync[1];
  assign scl_rise  = scl_s & ~scl_prev;
  assign scl_fall  = ~scl_s & scl_prev;
  assign start_det = scl_s & scl_prev & sda_prev & ~sda_s;
  assign stop_det  = scl_s & scl_prev & ~sda_prev & sda_s;

  state_t        state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shreg, shreg_n;
  logic          rw, rw_n;
  // phase: ACK states = ACK currently driven; RD_WAIT = byte latched;
  // RD_ACK = master acknowledged, waiting for the fall.
  logic          phase, phase_n;
  logic [HW-1:0] hold_cnt, hold_cnt_n;
  logic          hold_load, hold_done;
  logic          sda_oe_n, scl_oe_n, wr_valid_n, rd_req_n, start_n, stop_n, busy_n;
  logic [7:0]    wr_data_n;

  // hold_done fires SDA_HOLD clocks after the last load of the counter
  assign hold_done = (hold_cnt == HW'(1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      bit_cnt    <= 3'd0;
      shreg      <= 8'd0;
      rw         <= 1'b0;
      phase      <= 1'b0;
      hold_cnt   <= '0;
      sda_oe_o   <= 1'b0;
      scl_oe_o   <= 1'b0;
      wr_data_o  <= 8'd0;
      wr_valid_o <= 1'b0;
      rd_req_o   <= 1'b0;
      start_o    <= 1'b0;
      stop_o     <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      shreg      <= shreg_n;
      rw         <= rw_n;
      phase      <= phase_n;
      hold_cnt   <= hold_cnt_n;
      sda_oe_o   <= sda_oe_n;
      scl_oe_o   <= scl_oe_n;
      wr_data_o  <= wr_data_n;
      wr_valid_o <= wr_valid_n;
      rd_req_o   <= rd_req_n;
      start_o    <= start_n;
      stop_o     <= stop_n;
      busy_o     <= busy_n;
    end
  end

  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    rw_n       = rw;
    phase_n    = phase;
    sda_oe_n   = sda_oe_o;
    scl_oe_n   = scl_oe_o;
    wr_data_n  = wr_data_o;
    busy_n     = busy_o;
    wr_valid_n = 1'b0;
    rd_req_n   = 1'b0;
    start_n    = 1'b0;
    stop_n     = 1'b0;
    hold_load  = scl_fall;
    hold_cnt_n = hold_cnt;

    if (start_det || stop_det) begin
      sda_oe_n  = 1'b0;
      scl_oe_n  = 1'b0;
      bit_cnt_n = 3'd0;
      phase_n   = 1'b0;
      if (start_det) begin
        state_n = S_ADDR;
        start_n = 1'b1;
        busy_n  = 1'b1;
      end else begin
        state_n = S_IDLE;
        stop_n  = 1'b1;
        busy_n  = 1'b0;
      end
    end else begin
      case (state)
        S_IDLE, S_IGNORE: begin
          sda_oe_n = 1'b0;
          scl_oe_n = 1'b0;
        end
        S_ADDR: begin
          if (scl_rise) begin
            shreg_n   = {shreg[6:0], sda_s};
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              bit_cnt_n = 3'd0;
              if (shreg[6:0] == TARGET_ADDR) begin
                rw_n    = sda_s;
                state_n = S_ADDR_ACK;
              end else begin
                state_n = S_IGNORE;
              end
            end
          end
        end
        S_ADDR_ACK, S_WR_ACK: begin
          // Drive ACK after the 8th fall; leave at the 9th fall. The next
          // state releases SDA after its own hold delay.
          if (hold_done && !phase) begin
            sda_oe_n = 1'b1;
            phase_n  = 1'b1;
          end else if (scl_fall && phase) begin
            phase_n = 1'b0;
            if (state == S_ADDR_ACK && rw) begin
              state_n  = S_RD_WAIT;
              scl_oe_n = 1'b1;
              rd_req_n = 1'b1;
            end else begin
              state_n   = S_WR_BYTE;
              bit_cnt_n = 3'd0;
            end
          end
        end
        S_WR_BYTE: begin
          if (hold_done) sda_oe_n = 1'b0;
          if (scl_rise) begin
            shreg_n   = {shreg[6:0], sda_s};
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              bit_cnt_n = 3'd0;
              if (wr_ready_i) begin
                wr_data_n  = {shreg[6:0], sda_s};
                wr_valid_n = 1'b1;
                state_n    = S_WR_ACK;
              end else begin
                state_n = S_WR_NACK;
              end
            end
          end
        end
        S_WR_NACK: begin
          if (scl_rise) state_n = S_IGNORE;
        end
        S_RD_WAIT: begin
          if (!phase) begin
            if (rd_valid_i) begin
              phase_n   = 1'b1;
              shreg_n   = rd_data_i;
              sda_oe_n  = ~rd_data_i[7];
              hold_load = 1'b1;  // restart the delay before SCL is let go
            end else if (hold_done) begin
              sda_oe_n = 1'b0;   // end of the preceding ACK
            end
          end else if (hold_done) begin
            scl_oe_n  = 1'b0;
            phase_n   = 1'b0;
            bit_cnt_n = 3'd0;
            state_n   = S_RD_BYTE;
          end
        end
        S_RD_BYTE: begin
          // bit_cnt counts bits already presented; bit7 was set in RD_WAIT
          if (hold_done) begin
            if (bit_cnt == 3'd7) begin
              sda_oe_n = 1'b0;
              state_n  = S_RD_ACK;
            end else begin
              shreg_n   = {shreg[6:0], 1'b0};
              bit_cnt_n = bit_cnt + 3'd1;
              sda_oe_n  = ~shreg[6];
            end
          end
        end
        S_RD_ACK: begin
          if (scl_rise) begin
            if (sda_s) state_n = S_IGNORE;
            else       phase_n = 1'b1;
          end else if (scl_fall && phase) begin
            phase_n  = 1'b0;
            state_n  = S_RD_WAIT;
            scl_oe_n = 1'b1;
            rd_req_n = 1'b1;
          end
        end
        default: begin
          state_n  = S_IDLE;
          sda_oe_n = 1'b0;
          scl_oe_n = 1'b0;
        end
      endcase
    end

    if (hold_load)          hold_cnt_n = HW'(SDA_HOLD);
    else if (hold_cnt != 0) hold_cnt_n = hold_cnt - 1'b1;
  end

endmodule
